aes_block_assembler: RTL and testbench

Assembles a stream of 32-bit words into 128-bit AES blocks for the cipher core. It sits between the word-wide input interface and the round datapath. It drives the `flex_stp_ring` one-hot lane selector through that ring's `shift_enable` and `clear` inputs, and uses the ring's `parallel_out` to choose which lane of the block register each accepted word is written into.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_block_assembler_onehot_check.sv | 28 ++
 rtl/aes_block_assembler.sv | 108 ++++++++++
 tb/tb_aes_block_assembler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES word/block datapath.
// Word 0 of a block sits in the MSBs (big-endian byte order).
package aes_pkg;

  localparam int WORD_W  = 32;
  localparam int WORDS   = 4;
  localparam int BLOCK_W = WORD_W * WORDS;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } asm_state_t;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/aes_block_assembler_onehot_check.sv
// Combinational one-hot validator for a lane-select vector; also yields the
// binary lane index. Shared with the output disassembler.
module onehot_check #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     sel,
  output logic             is_onehot,
  output logic [IDX_W-1:0] idx
);

  localparam int CNT_W = $clog2(N + 1);

  logic [CNT_W-1:0] w_ones;

  always_comb begin
    w_ones = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        w_ones = w_ones + CNT_W'(1);
        idx    = IDX_W'(i);
      end
    end
    is_onehot = (w_ones == CNT_W'(1));
  end

endmodule

// File: rtl/aes_block_assembler.sv
// Packs 32-bit words into 128-bit AES blocks, steering each accepted word
// into the lane chosen by an external one-hot ring.
module aes_block_assembler #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        in_ready,
  input  logic                        flush,
  input  logic [WORDS-1:0]            ring_sel,
  output logic                        ring_shift,
  output logic                        ring_clear,
  output logic                        out_valid,
  output logic [WORD_W*WORDS-1:0]     out_data,
  input  logic                        out_ready,
  output logic [$clog2(WORDS+1)-1:0]  word_cnt,
  output logic                        sel_err
);

  import aes_pkg::*;

  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  asm_state_t                r_state;
  logic [CNT_W-1:0]          r_word_cnt;
  logic [WORD_W*WORDS-1:0]   r_block;
  logic                      r_sel_err;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_onehot;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_wr;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(WORDS)) ? c : c + CNT_W'(1);
  endfunction

  onehot_check #(
    .N     (WORDS),
    .IDX_W (IDX_W)
  ) u_onehot_check (
    .sel       (ring_sel),
    .is_onehot (w_onehot),
    .idx       (w_idx)
  );

  // In FULL the input is only open when the held block leaves this cycle.
  assign w_in_ready = ~flush & ((r_state == FILL) | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_wr       = w_accept & w_onehot;

  assign in_ready   = w_in_ready;
  assign ring_shift = w_accept;
  assign ring_clear = flush;
  assign out_valid  = (r_state == FULL);
  assign out_data   = r_block;
  assign word_cnt   = r_word_cnt;
  assign sel_err    = r_sel_err;

  // Stage p0: lane write, counter and state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_word_cnt <= '0;
      r_block    <= '0;
      r_sel_err  <= 1'b0;
    end else if (flush) begin
      r_state    <= FILL;
      r_word_cnt <= '0;
      r_sel_err  <= 1'b0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (w_wr && (w_idx == IDX_W'(i))) begin
          r_block[WORD_W*(WORDS-i)-1 -: WORD_W] <= in_data;
        end
      end
      if (w_accept && !w_onehot) begin
        r_sel_err <= 1'b1;
      end
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_word_cnt <= cnt_inc(r_word_cnt);
            if (ring_sel[WORDS-1]) begin
              r_state <= FULL;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            r_state    <= FILL;
            r_word_cnt <= w_accept ? CNT_W'(1) : '0;
          end
        end
        default: begin
          r_state    <= FILL;
          r_word_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_assembler.sv
// Bench for aes_block_assembler with a behavioural lane ring and a block scoreboard.
module tb_aes_block_assembler;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          flush;
  logic [3:0]    ring_sel;
  logic          ring_shift;
  logic          ring_clear;
  logic          out_valid;
  logic [127:0]  out_data;
  logic          out_ready;
  logic [2:0]    word_cnt;
  logic          sel_err;

  logic [3:0]    r_ring;
  logic          force_en;
  logic [3:0]    force_val;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [127:0]  q[$];
  logic [127:0]  exp_blk;
  int            exp_lane;
  logic [127:0]  snap;

  always #5 clk = ~clk;

  aes_block_assembler #(.WORD_W(32), .WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .ring_sel   (ring_sel),
    .ring_shift (ring_shift),
    .ring_clear (ring_clear),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .word_cnt   (word_cnt),
    .sel_err    (sel_err)
  );

  // Behavioural stand-in for the one-hot ring: resets/clears to 0001, rotates up.
  always @(posedge clk or posedge rst) begin
    if (rst)             r_ring <= 4'b0001;
    else if (ring_clear) r_ring <= 4'b0001;
    else if (ring_shift) r_ring <= {r_ring[2:0], r_ring[3]};
  end
  assign ring_sel = force_en ? force_val : r_ring;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every block transfer is compared against the oldest expected block.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL blk_unexpected: got %h expected none", out_data);
      end else begin
        chk("blk", out_data, q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    chk("in_ready", {127'd0, in_ready}, 128'd1);
    chk("ring_shift", {127'd0, ring_shift}, 128'd1);
    exp_blk[127-32*exp_lane -: 32] = d;
    exp_lane++;
    if (exp_lane == 4) begin
      q.push_back(exp_blk);
      exp_lane = 0;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    force_en = 1'b0; force_val = 4'b0000; exp_blk = '0; exp_lane = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready",   {127'd0, in_ready},   128'd1);
    chk("rst_out_valid",  {127'd0, out_valid},  128'd0);
    chk("rst_out_data",   out_data,             128'd0);
    chk("rst_word_cnt",   {125'd0, word_cnt},   128'd0);
    chk("rst_sel_err",    {127'd0, sel_err},    128'd0);
    chk("rst_ring_shift", {127'd0, ring_shift}, 128'd0);
    chk("rst_ring_clear", {127'd0, ring_clear}, 128'd0);
    step();
    rst = 1'b0;
    step();

    // Fill one block back-to-back with the sink ready
    out_ready = 1'b1;
    send(32'h00112233);
    send(32'h44556677);
    send(32'h8899AABB);
    @(negedge clk);
    chk("lat_out_valid_c3", {127'd0, out_valid}, 128'd0);
    step();
    send(32'hCCDDEEFF);
    chk("fill_expect", q[0], 128'h00112233_44556677_8899AABB_CCDDEEFF);
    @(negedge clk);
    chk("lat_out_valid_c4", {127'd0, out_valid},  128'd1);
    chk("fill_word_cnt",    {125'd0, word_cnt},   128'd4);
    chk("fill_shift_idle",  {127'd0, ring_shift}, 128'd0);
    step();
    @(negedge clk);
    chk("fill_drain_valid", {127'd0, out_valid}, 128'd0);
    chk("fill_drain_cnt",   {125'd0, word_cnt},  128'd0);
    step();

    // Backpressure with upstream still offering data
    out_ready = 1'b0;
    send(32'h01010101);
    send(32'h02020202);
    send(32'h03030303);
    send(32'h04040404);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hBAD00000 + i;
      @(negedge clk);
      chk("bp_in_ready", {127'd0, in_ready},   128'd0);
      chk("bp_word_cnt", {125'd0, word_cnt},   128'd4);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_out_data", out_data, 128'h01010101_02020202_03030303_04040404);
      chk("bp_shift",    {127'd0, ring_shift}, 128'd0);
      step();
    end
    out_ready = 1'b1;
    send(32'hDEADBEEF);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", {127'd0, out_valid}, 128'd0);
    chk("bp_after_cnt",   {125'd0, word_cnt},  128'd1);
    chk("bp_after_lane0", {96'd0, out_data[127:96]}, 128'hDEADBEEF);
    step();
    out_ready = 1'b1;
    send(32'h11111111);
    send(32'h22222222);
    send(32'h33333333);
    idle();

    // Flush part-way through a block
    send(32'hA0A0A0A0);
    send(32'hB0B0B0B0);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("fl_ring_clear", {127'd0, ring_clear}, 128'd1);
    chk("fl_in_ready",   {127'd0, in_ready},   128'd0);
    chk("fl_ring_shift", {127'd0, ring_shift}, 128'd0);
    exp_lane = 0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_word_cnt",   {125'd0, word_cnt},   128'd0);
    chk("fl_clear_low",  {127'd0, ring_clear}, 128'd0);
    step();
    send(32'hC1C1C1C1);
    send(32'hC2C2C2C2);
    send(32'hC3C3C3C3);
    send(32'hC4C4C4C4);
    idle();

    // Flush while a block is held: not transferred, valid withdrawn
    out_ready = 1'b0;
    send(32'h5A5A0001);
    send(32'h5A5A0002);
    send(32'h5A5A0003);
    send(32'h5A5A0004);
    @(negedge clk);
    chk("flf_valid", {127'd0, out_valid}, 128'd1);
    step();
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flf_clear", {127'd0, ring_clear}, 128'd1);
    void'(q.pop_back());
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flf_valid_drop", {127'd0, out_valid}, 128'd0);
    chk("flf_word_cnt",   {125'd0, word_cnt},  128'd0);
    step();

    // Continuous stream of three blocks
    for (int i = 0; i < 12; i++) send(32'h70000000 + 32'(i * 32'h01010101));
    idle();

    // Non-one-hot lane select at an accept
    snap = out_data;
    force_en = 1'b1; force_val = 4'b0011;
    in_valid = 1'b1; in_data = 32'hAAAA5555;
    @(negedge clk);
    chk("se_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    force_en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("se_flag",     {127'd0, sel_err},  128'd1);
    chk("se_word_cnt", {125'd0, word_cnt}, 128'd1);
    chk("se_no_write", out_data, snap);
    step();
    repeat (3) step();
    @(negedge clk);
    chk("se_sticky", {127'd0, sel_err}, 128'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("se_cleared", {127'd0, sel_err},  128'd0);
    chk("se_cnt_clr", {125'd0, word_cnt}, 128'd0);
    step();

    // Asynchronous reset after three words
    send(32'hE0000001);
    send(32'hE0000002);
    send(32'hE0000003);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ar_out_data",  out_data,             128'd0);
    chk("ar_word_cnt",  {125'd0, word_cnt},   128'd0);
    chk("ar_out_valid", {127'd0, out_valid},  128'd0);
    chk("ar_in_ready",  {127'd0, in_ready},   128'd1);
    chk("ar_sel_err",   {127'd0, sel_err},    128'd0);
    #1 rst = 1'b0;
    exp_lane = 0;
    step();
    send(32'hF0000001);
    send(32'hF0000002);
    send(32'hF0000003);
    send(32'hF0000004);
    idle();
    idle();

    chk("q_drained", 128'(q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
